// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - signal bundle between MCS IO masters, the arbiter and the external IO bus
//
// Purpose : groups the per-master request/response vectors, the external IO bus
//           and the error reporting signals of io_bus_arbiter.
// Modports: slave  - arbiter view (takes master strobes and io_din/io_ready,
//                    drives m_rdata/m_ready, the io_* strobes and err).
//           master - requester/fabric view (the mirror image).
// Signals : m_as/m_rs/m_ws [N]       per-master strobes
//           m_addr [N*ADDR_W]        per-master address, master i at slice i
//           m_be [N*BE_W]            per-master byte enables
//           m_wdata/m_rdata [N*DATA_W] per-master write / read data
//           m_ready [N]              per-master completion pulse
//           io_ae/io_re/io_we        external strobes
//           io_sa/io_bytes/io_dout   external address, byte enables, write data
//           io_din/io_ready          external read data and completion
//           err/err_master/err_clr   sticky timeout flag, offending master, clear

interface io_bus_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [NUM_MASTERS-1:0]        m_as;
   logic [NUM_MASTERS-1:0]        m_rs;
   logic [NUM_MASTERS-1:0]        m_ws;
   logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
   logic [NUM_MASTERS*BE_W-1:0]   m_be;
   logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
   logic [NUM_MASTERS*DATA_W-1:0] m_rdata;
   logic [NUM_MASTERS-1:0]        m_ready;

   logic                          io_ae;
   logic                          io_re;
   logic                          io_we;
   logic [ADDR_W-1:0]             io_sa;
   logic [BE_W-1:0]               io_bytes;
   logic [DATA_W-1:0]             io_dout;
   logic [DATA_W-1:0]             io_din;
   logic                          io_ready;

   logic                          err;
   logic [IDX_W-1:0]              err_master;
   logic                          err_clr;

   modport slave (
      input  m_as, m_rs, m_ws, m_addr, m_be, m_wdata,
      output m_rdata, m_ready,
      output io_ae, io_re, io_we, io_sa, io_bytes, io_dout,
      input  io_din, io_ready,
      output err, err_master,
      input  err_clr
   );

   modport master (
      output m_as, m_rs, m_ws, m_addr, m_be, m_wdata,
      input  m_rdata, m_ready,
      input  io_ae, io_re, io_we, io_sa, io_bytes, io_dout,
      output io_din, io_ready,
      input  err, err_master,
      output err_clr
   );
endinterface

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin N-master MicroBlaze MCS IO bus arbiter with timeout
//
// Purpose : captures one-cycle IO strobes from NUM_MASTERS masters into request
//           slots, grants them round-robin onto a single external IO bus and
//           returns read data / ready to the owning master only. Accesses whose
//           slave never answers are force-completed after TIMEOUT cycles.
// Ports   : clk  - system clock
//           rst  - asynchronous active-high reset
//           bus  - io_bus_arbiter_if.slave (master request/response vectors,
//                  external IO bus, err/err_master/err_clr)

module io_bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic               clk,
   input  logic               rst,
   io_bus_arbiter_if.slave    bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   // Counter value seen in the last ISSUE/WAIT cycle before a forced completion.
   localparam logic [TW-1:0]    TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   // Request slots
   logic [NUM_MASTERS-1:0]        pend_q;
   logic [NUM_MASTERS-1:0]        rs_q;
   logic [NUM_MASTERS-1:0]        ws_q;
   logic [NUM_MASTERS*ADDR_W-1:0] addr_q;
   logic [NUM_MASTERS*BE_W-1:0]   be_q;
   logic [NUM_MASTERS*DATA_W-1:0] wdata_q;

   // FSM and registered outputs
   state_t                        state_q;
   logic [IDX_W-1:0]              grant_q;
   logic [IDX_W-1:0]              last_grant_q;
   logic [TW-1:0]                 tcnt_q;
   logic                          io_ae_q;
   logic                          io_re_q;
   logic                          io_we_q;
   logic [ADDR_W-1:0]             io_sa_q;
   logic [BE_W-1:0]               io_bytes_q;
   logic [DATA_W-1:0]             io_dout_q;
   logic [NUM_MASTERS-1:0]        m_ready_q;
   logic [NUM_MASTERS*DATA_W-1:0] m_rdata_q;
   logic                          err_q;
   logic [IDX_W-1:0]              err_master_q;

   // Combinational helpers
   logic                          busy;
   logic                          grant_vld;
   logic [IDX_W-1:0]              grant_idx;
   logic                          grant_fire;
   logic                          tmo_hit;
   logic [NUM_MASTERS-1:0]        accept;

   // Only ISSUE/WAIT count as ownership: during DONE the owner may already
   // strobe its next request.
   assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign grant_fire = (state_q == S_IDLE) && grant_vld;
   assign tmo_hit    = (TIMEOUT > 0) && (tcnt_q == TO_LAST);

   // Round-robin search starting just after the last granted master.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] idx_v;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      idx_v     = '0;
      for (int off = 1; off <= NUM_MASTERS; off++) begin
         idx = int'(last_grant_q) + off;
         if (idx >= NUM_MASTERS) begin
            idx = idx - NUM_MASTERS;
         end
         idx_v = IDX_W'(idx);
         if (!grant_vld && pend_q[idx_v]) begin
            grant_vld = 1'b1;
            grant_idx = idx_v;
         end
      end
   end

   // A strobe is dropped if its slot is still full or its master owns the bus.
   always_comb begin
      accept = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         accept[i] = bus.m_as[i] && !pend_q[i] && !(busy && (grant_q == IDX_W'(i)));
      end
   end

   // Slot capture and release. Accept and grant never hit the same slot in one
   // cycle: accept needs the slot empty, grant needs it full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q  <= '0;
         rs_q    <= '0;
         ws_q    <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (accept[i]) begin
               pend_q[i]                     <= 1'b1;
               rs_q[i]                       <= bus.m_rs[i];
               ws_q[i]                       <= bus.m_ws[i];
               addr_q[i*ADDR_W +: ADDR_W]    <= bus.m_addr[i*ADDR_W +: ADDR_W];
               be_q[i*BE_W +: BE_W]          <= bus.m_be[i*BE_W +: BE_W];
               wdata_q[i*DATA_W +: DATA_W]   <= bus.m_wdata[i*DATA_W +: DATA_W];
            end else if (grant_fire && (grant_idx == IDX_W'(i))) begin
               pend_q[i] <= 1'b0;
            end
         end
      end
   end

   // Access FSM with registered bus and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_RST;
         tcnt_q       <= '0;
         io_ae_q      <= 1'b0;
         io_re_q      <= 1'b0;
         io_we_q      <= 1'b0;
         io_sa_q      <= '0;
         io_bytes_q   <= '0;
         io_dout_q    <= '0;
         m_ready_q    <= '0;
         m_rdata_q    <= '0;
         err_q        <= 1'b0;
         err_master_q <= '0;
      end else begin
         m_ready_q <= '0;
         // A timeout in this same cycle assigns err later and therefore wins.
         if (bus.err_clr) begin
            err_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (grant_vld) begin
                  grant_q      <= grant_idx;
                  last_grant_q <= grant_idx;
                  io_ae_q      <= 1'b1;
                  io_re_q      <= rs_q[grant_idx];
                  io_we_q      <= ws_q[grant_idx];
                  io_sa_q      <= addr_q[int'(grant_idx)*ADDR_W +: ADDR_W];
                  io_bytes_q   <= be_q[int'(grant_idx)*BE_W +: BE_W];
                  io_dout_q    <= wdata_q[int'(grant_idx)*DATA_W +: DATA_W];
                  tcnt_q       <= '0;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE, S_WAIT: begin
               io_ae_q <= 1'b0;
               io_re_q <= 1'b0;
               io_we_q <= 1'b0;
               tcnt_q  <= tcnt_q + TW'(1);
               if (bus.io_ready) begin
                  m_rdata_q[int'(grant_q)*DATA_W +: DATA_W] <= bus.io_din;
                  m_ready_q[grant_q]                        <= 1'b1;
                  state_q                                   <= S_DONE;
               end else if (tmo_hit) begin
                  m_rdata_q[int'(grant_q)*DATA_W +: DATA_W] <= '0;
                  m_ready_q[grant_q]                        <= 1'b1;
                  err_q                                     <= 1'b1;
                  err_master_q                              <= grant_q;
                  state_q                                   <= S_DONE;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.io_ae      = io_ae_q;
   assign bus.io_re      = io_re_q;
   assign bus.io_we      = io_we_q;
   assign bus.io_sa      = io_sa_q;
   assign bus.io_bytes   = io_bytes_q;
   assign bus.io_dout    = io_dout_q;
   assign bus.m_ready    = m_ready_q;
   assign bus.m_rdata    = m_rdata_q;
   assign bus.err        = err_q;
   assign bus.err_master = err_master_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - directed self-checking bench for io_bus_arbiter

module tb_io_bus_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   io_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   io_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; pulse-type inputs are released right after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
      bus.m_as     = '0;
      bus.m_rs     = '0;
      bus.m_ws     = '0;
      bus.io_ready = 1'b0;
      bus.err_clr  = 1'b0;
   endtask

   task automatic strobe(input int i, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
      bus.m_as[i]             = 1'b1;
      bus.m_rs[i]             = rd;
      bus.m_ws[i]             = wr;
      bus.m_addr[i*32 +: 32]  = a;
      bus.m_be[i*4 +: 4]      = be;
      bus.m_wdata[i*32 +: 32] = wd;
   endtask

   task automatic do_reset;
      rst          = 1'b1;
      bus.m_as     = '0;
      bus.m_rs     = '0;
      bus.m_ws     = '0;
      bus.m_addr   = '0;
      bus.m_be     = '0;
      bus.m_wdata  = '0;
      bus.io_din   = '0;
      bus.io_ready = 1'b0;
      bus.err_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n_done;
      int we_cnt;
      int bad_ae;
      int bad_rdy;
      n_checks = 0;
      n_errors = 0;

      // Reset state and single read
      do_reset;
      check("rst_ae", bus.io_ae, 0);
      check("rst_re_we", {bus.io_re, bus.io_we}, 0);
      check("rst_sa", bus.io_sa, 0);
      check("rst_mready", bus.m_ready, 0);
      check("rst_rdata_zero", bus.m_rdata == '0, 1);
      check("rst_err", bus.err, 0);
      check("rst_errm", bus.err_master, 0);
      strobe(0, 1, 0, 32'hC000_0010, 4'hF, 32'h0);
      tick;
      check("rd_ae_c1", bus.io_ae, 0);
      tick;
      check("rd_ae_c2", bus.io_ae, 1);
      check("rd_re_c2", bus.io_re, 1);
      check("rd_we_c2", bus.io_we, 0);
      check("rd_sa_c2", bus.io_sa, 32'hC000_0010);
      tick;
      check("rd_ae_c3", bus.io_ae, 0);
      check("rd_re_c3", bus.io_re, 0);
      bus.io_ready = 1'b1;
      bus.io_din   = 32'h1234_5678;
      tick;
      check("rd_mready_c4", bus.m_ready, 4'b0001);
      check("rd_rdata0", bus.m_rdata[31:0], 32'h1234_5678);
      tick;
      check("rd_mready_c5", bus.m_ready, 0);

      // Simultaneous requests, slave ready whenever io_ae
      do_reset;
      strobe(0, 1, 0, 32'hA000_0000, 4'hF, 0);
      strobe(1, 1, 0, 32'hA000_0004, 4'hF, 0);
      for (int c = 1; c <= 8; c++) begin
         tick;
         check($sformatf("sim_ae_c%0d", c), bus.io_ae, (c == 2 || c == 5) ? 1 : 0);
         check($sformatf("sim_rdy_c%0d", c), bus.m_ready,
               (c == 3) ? 4'b0001 : (c == 6) ? 4'b0010 : 4'b0000);
         if (c == 2) check("sim_sa_m0", bus.io_sa, 32'hA000_0000);
         if (c == 5) check("sim_sa_m1", bus.io_sa, 32'hA000_0004);
         bus.io_ready = bus.io_ae;
         bus.io_din   = 32'h5000_0000 + c;
      end

      // Round-robin, every master re-strobes on its own m_ready
      do_reset;
      for (int i = 0; i < N; i++) strobe(i, 1, 0, 32'hB000_0000 + i, 4'hF, 0);
      n_done = 0;
      for (int c = 1; c <= 200 && n_done < 8; c++) begin
         tick;
         if (bus.m_ready != 0) begin
            check($sformatf("rr_order_%0d", n_done), bus.m_ready, 4'b0001 << (n_done % 4));
            for (int i = 0; i < N; i++)
               if (bus.m_ready[i]) strobe(i, 1, 0, 32'hB000_0000 + i, 4'hF, 0);
            n_done++;
         end
         bus.io_ready = bus.io_ae;
      end
      check("rr_completions", n_done, 8);

      // Write with byte enables, delayed ready, dropped owner strobe, captured non-owner strobe
      do_reset;
      strobe(1, 0, 1, 32'hC000_0020, 4'b0011, 32'hAABB_CCDD);
      we_cnt = 0;
      bad_ae = 0;
      for (int c = 1; c <= 18; c++) begin
         tick;
         if (bus.io_we) we_cnt++;
         if (c == 2) begin
            check("wr_ae", bus.io_ae, 1);
            check("wr_re", bus.io_re, 0);
            check("wr_bytes", bus.io_bytes, 4'b0011);
            check("wr_dout", bus.io_dout, 32'hAABB_CCDD);
         end
         if (c >= 3 && c <= 8) begin
            check($sformatf("wr_hold_c%0d", c), {bus.io_ae, bus.io_sa, bus.io_bytes, bus.io_dout},
                  {1'b0, 32'hC000_0020, 4'b0011, 32'hAABB_CCDD});
         end
         if (c == 4) begin
            strobe(1, 1, 0, 32'h0000_0999, 4'hF, 0);
            strobe(0, 1, 0, 32'hC000_0030, 4'hF, 0);
         end
         if (c == 7) bus.io_ready = 1'b1;
         if (c == 8) check("wr_mready", bus.m_ready, 4'b0010);
         if (c == 10) begin
            check("cap_ae", bus.io_ae, 1);
            check("cap_sa", bus.io_sa, 32'hC000_0030);
            bus.io_ready = 1'b1;
            bus.io_din   = 32'h0BAD_F00D;
         end
         if (c == 11) check("cap_mready", bus.m_ready, 4'b0001);
         if (c > 11 && bus.io_ae) bad_ae++;
      end
      check("wr_we_pulses", we_cnt, 1);
      check("drop_owner_no_ae", bad_ae, 0);

      // Timeout: preload master 2 rdata, then an unanswered read
      do_reset;
      strobe(2, 1, 0, 32'hC000_0040, 4'hF, 0);
      tick;
      tick;
      bus.io_ready = 1'b1;
      bus.io_din   = 32'hDEAD_BEEF;
      tick;
      check("pre_rdata2", bus.m_rdata[95:64], 32'hDEAD_BEEF);
      tick;
      strobe(2, 1, 0, 32'hC000_0044, 4'hF, 0);
      bad_rdy = 0;
      for (int c = 1; c <= 13; c++) begin
         tick;
         if (c == 2) check("to_ae", bus.io_ae, 1);
         if (c >= 3 && c <= 9 && bus.m_ready != 0) bad_rdy++;
         if (c == 10) begin
            check("to_mready", bus.m_ready, 4'b0100);
            check("to_rdata_zero", bus.m_rdata[95:64], 0);
            check("to_err", bus.err, 1);
            check("to_errm", bus.err_master, 2);
         end
         if (c == 11) begin
            bus.io_ready = 1'b1;
            bus.io_din   = 32'h7777_7777;
         end
         if (c == 12) begin
            check("late_rdy_ignored", bus.m_ready, 0);
            check("late_rdata", bus.m_rdata[95:64], 0);
            check("err_sticky", bus.err, 1);
            bus.err_clr = 1'b1;
         end
         if (c == 13) check("err_cleared", bus.err, 0);
      end
      check("to_no_early_ready", bad_rdy, 0);

      // Timeout and err_clr in the same cycle: set wins
      strobe(3, 1, 0, 32'hC000_0048, 4'hF, 0);
      for (int c = 1; c <= 10; c++) begin
         tick;
         if (c == 9) bus.err_clr = 1'b1;
         if (c == 10) begin
            check("setwins_mready", bus.m_ready, 4'b1000);
            check("setwins_err", bus.err, 1);
            check("setwins_errm", bus.err_master, 3);
         end
      end

      // Reset during WAIT with master 1 pending
      do_reset;
      strobe(0, 1, 0, 32'hC000_0050, 4'hF, 0);
      tick;
      strobe(1, 0, 1, 32'hC000_0060, 4'hF, 32'h1111_2222);
      tick;
      tick;
      check("mid_sa", bus.io_sa, 32'hC000_0050);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ae_re_we", {bus.io_ae, bus.io_re, bus.io_we}, 0);
      check("arst_sa", bus.io_sa, 0);
      check("arst_bytes_dout", {bus.io_bytes, bus.io_dout}, 0);
      check("arst_mready", bus.m_ready, 0);
      check("arst_err", {bus.err, bus.err_master}, 0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      bad_ae  = 0;
      bad_rdy = 0;
      for (int c = 0; c < 12; c++) begin
         tick;
         if (bus.io_ae) bad_ae++;
         if (bus.m_ready != 0) bad_rdy++;
      end
      check("post_rst_no_ae", bad_ae, 0);
      check("post_rst_no_ready", bad_rdy, 0);
      strobe(1, 1, 0, 32'hC000_0070, 4'hF, 0);
      tick;
      tick;
      check("post_rst_new_ae", bus.io_ae, 1);
      check("post_rst_new_sa", bus.io_sa, 32'hC000_0070);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
